alu_seq: RTL and testbench

Registered, parametrised successor to the combinational CPU ALU. It latches operands on a start/busy/valid handshake, computes in one cycle, and optionally adds one cycle for BCD decimal adjust. It also adds shift/rotate, INC/DEC and BIT operations. It sits between the CPU decode/microsequencer and the register file/flag register P, and also serves effective-address adds.

---
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised CPU ALU with a start/busy/valid handshake.
// Operands are latched in IDLE, computed in EXEC, and (when the ALU_DECIMAL_EN
// macro is defined) ADC/SBC with the D flag set take one extra ADJ cycle for
// BCD correction. Flags use the 6502 layout N7 V6 -5 B4 D3 I2 Z1 C0.
module alu_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   alu,
  input  logic [7:0]   P,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] alu_res,
  output logic [7:0]   alu_flag
);

  localparam logic [3:0] OP_ORA = 4'h0, OP_AND = 4'h1, OP_EOR = 4'h2, OP_ADC = 4'h3;
  localparam logic [3:0] OP_PSA = 4'h4, OP_PSB = 4'h5, OP_CMP = 4'h6, OP_SBC = 4'h7;
  localparam logic [3:0] OP_ADD = 4'h8, OP_ASL = 4'h9, OP_LSR = 4'hA, OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC, OP_INC = 4'hD, OP_DEC = 4'hE, OP_BIT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef ALU_DECIMAL_EN
    S_ADJ,
`endif
    S_EXEC
  } state_t;

  state_t       state_q;
  logic [W-1:0] a_q, b_q, res_q;
  logic [3:0]   op_q;
  logic [7:0]   p_q, flag_q;
  logic         valid_q;

  logic [W-1:0] x_op;
  logic         cin;
  logic [W:0]   sum;
  logic [W-1:0] res_d;
  logic [7:0]   flag_d;
  logic         upd_nz;

  // Shared adder operand select: SBC/CMP add the inverted B (C means no borrow).
  always_comb begin
    x_op = b_q;
    cin  = 1'b0;
    case (op_q)
      OP_ADC:  cin = p_q[0];
      OP_SBC:  begin x_op = ~b_q; cin = p_q[0]; end
      OP_CMP:  begin x_op = ~b_q; cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, a_q} + {1'b0, x_op} + {{W{1'b0}}, cin};

  // Binary result and flags; flags not touched by an op are copied from latched P.
  always_comb begin
    res_d  = a_q;
    flag_d = p_q;
    upd_nz = 1'b0;
    case (op_q)
      OP_ORA: begin res_d = a_q | b_q; upd_nz = 1'b1; end
      OP_AND: begin res_d = a_q & b_q; upd_nz = 1'b1; end
      OP_EOR: begin res_d = a_q ^ b_q; upd_nz = 1'b1; end
      OP_ADC: begin
        res_d     = sum[W-1:0];
        upd_nz    = 1'b1;
        flag_d[0] = sum[W];
        flag_d[6] = ~(a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ sum[W-1]);
      end
      OP_PSA: res_d = a_q;
      OP_PSB: begin res_d = b_q; upd_nz = 1'b1; end
      OP_CMP: begin
        res_d     = a_q;
        flag_d[7] = sum[W-1];
        flag_d[1] = (sum[W-1:0] == '0);
        flag_d[0] = sum[W];
      end
      OP_SBC: begin
        res_d     = sum[W-1:0];
        upd_nz    = 1'b1;
        flag_d[0] = sum[W];
        flag_d[6] = (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ sum[W-1]);
      end
      OP_ADD: begin res_d = sum[W-1:0]; flag_d[0] = sum[W]; end
      OP_ASL: begin res_d = {a_q[W-2:0], 1'b0};   flag_d[0] = a_q[W-1]; upd_nz = 1'b1; end
      OP_LSR: begin res_d = {1'b0, a_q[W-1:1]};   flag_d[0] = a_q[0];   upd_nz = 1'b1; end
      OP_ROL: begin res_d = {a_q[W-2:0], p_q[0]}; flag_d[0] = a_q[W-1]; upd_nz = 1'b1; end
      OP_ROR: begin res_d = {p_q[0], a_q[W-1:1]}; flag_d[0] = a_q[0];   upd_nz = 1'b1; end
      OP_INC: begin res_d = b_q + W'(1); upd_nz = 1'b1; end
      OP_DEC: begin res_d = b_q - W'(1); upd_nz = 1'b1; end
      OP_BIT: begin
        res_d     = a_q;
        flag_d[1] = ((a_q & b_q) == '0);
        flag_d[7] = b_q[W-1];
        flag_d[6] = b_q[W-2];
      end
      default: ;
    endcase
    if (upd_nz) begin
      flag_d[7] = res_d[W-1];
      flag_d[1] = (res_d == '0);
    end
  end

`ifdef ALU_DECIMAL_EN
  localparam int NN = W / 4;

  logic [NN-1:0] nib_c, nc_q;
  logic [W-1:0]  bin_res_q, dec_res;
  logic [7:0]    bin_flag_q, dec_flag;
  logic [4:0]    dec_t;
  logic          dec_rc;
  logic          dec_apply;

  // Carry out of each nibble of the binary add (for SBC: 1 = no borrow).
  for (genvar gi = 0; gi < NN; gi++) begin : g_nib
    if (gi == NN - 1) begin : g_top
      assign nib_c[gi] = sum[W];
    end else begin : g_mid
      assign nib_c[gi] = sum[4*gi+4] ^ a_q[4*gi+4] ^ x_op[4*gi+4];
    end
  end

  assign dec_apply = ((op_q == OP_ADC) || (op_q == OP_SBC)) && p_q[3];

  // BCD correction of the registered binary result, nibble by nibble from the LSB.
  always_comb begin
    dec_res = bin_res_q;
    dec_rc  = 1'b0;
    dec_t   = '0;
    for (int i = 0; i < NN; i++) begin
      if (op_q == OP_SBC) begin
        dec_t = {1'b0, bin_res_q[4*i +: 4]};
        if (!nc_q[i]) dec_t = dec_t - 5'd6;
        dec_rc = nc_q[i];
      end else begin
        dec_t = {1'b0, bin_res_q[4*i +: 4]} + {4'b0000, dec_rc};
        if ((dec_t > 5'd9) || nc_q[i]) dec_t = dec_t + 5'd6;
        dec_rc = dec_t[4] | nc_q[i];
      end
      dec_res[4*i +: 4] = dec_t[3:0];
    end
    dec_flag    = bin_flag_q;
    dec_flag[7] = dec_res[W-1];
    dec_flag[1] = (dec_res == '0);
    dec_flag[0] = dec_rc;
  end
`endif

  // Handshake FSM: latch in IDLE, compute in EXEC, optional decimal ADJ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      res_q      <= '0;
      flag_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      p_q        <= '0;
`ifdef ALU_DECIMAL_EN
      bin_res_q  <= '0;
      bin_flag_q <= '0;
      nc_q       <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= alu;
            p_q     <= P;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
`ifdef ALU_DECIMAL_EN
          if (dec_apply) begin
            bin_res_q  <= res_d;
            bin_flag_q <= flag_d;
            nc_q       <= nib_c;
            state_q    <= S_ADJ;
          end else begin
            res_q   <= res_d;
            flag_q  <= flag_d;
            valid_q <= 1'b1;
            state_q <= S_IDLE;
          end
`else
          res_q   <= res_d;
          flag_q  <= flag_d;
          valid_q <= 1'b1;
          state_q <= S_IDLE;
`endif
        end
`ifdef ALU_DECIMAL_EN
        S_ADJ: begin
          res_q   <= dec_res;
          flag_q  <= dec_flag;
          valid_q <= 1'b1;
          state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign valid    = valid_q;
  assign alu_res  = res_q;
  assign alu_flag = flag_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq: one W=8 instance and one W=16 instance.
// Expected values adapt to whether ALU_DECIMAL_EN is defined.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, busy8, valid8;
  logic [7:0]  a8, b8, p8, res8, flag8;
  logic [3:0]  op8;
  logic        start16, busy16, valid16;
  logic [15:0] a16, b16, res16;
  logic [7:0]  p16, flag16;
  logic [3:0]  op16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .alu(op8), .P(p8),
    .busy(busy8), .valid(valid8), .alu_res(res8), .alu_flag(flag8)
  );

  alu_seq #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .alu(op16), .P(p16),
    .busy(busy16), .valid(valid16), .alu_res(res16), .alu_flag(flag16)
  );

  // Drive a request for one edge (caller sits #1 after a rising edge).
  task automatic go8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] p);
    op8 = op; a8 = a; b8 = b; p8 = p; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Count edges since the accepting edge until valid; 99 means timeout.
  task automatic wait8(output int lat);
    bit done;
    done = 0;
    lat  = 1;
    for (int n = 0; n < 8 && !done; n++) begin
      @(posedge clk); #1;
      lat++;
      if (valid8) done = 1;
    end
    if (!done) lat = 99;
  endtask

  task automatic test_reset;
    total++; if (busy8 !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    total++; if (valid8 !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", valid8); end
    total++; if (res8 !== 8'h00)   begin bad++; $display("FAIL reset_res got=%h exp=00", res8); end
    total++; if (flag8 !== 8'h00)  begin bad++; $display("FAIL reset_flag got=%h exp=00", flag8); end
    $display("reset: busy=%b valid=%b res=%h flag=%h", busy8, valid8, res8, flag8);
  endtask

  task automatic test_adc;
    int lat;
    go8(4'h3, 8'h7F, 8'h01, 8'h00);
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL adc_busy got=%b exp=1", busy8); end
    wait8(lat);
    $display("ADC 7F+01 P=00 -> res=%h flag=%h lat=%0d", res8, flag8, lat);
    total++; if (lat != 2)       begin bad++; $display("FAIL adc_lat got=%0d exp=2", lat); end
    total++; if (res8 !== 8'h80) begin bad++; $display("FAIL adc_res got=%h exp=80", res8); end
    total++; if (flag8 !== 8'hC0) begin bad++; $display("FAIL adc_flag got=%h exp=C0", flag8); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL adc_busy_at_valid got=%b exp=0", busy8); end
    @(posedge clk); #1;
    total++; if (valid8 !== 1'b0) begin bad++; $display("FAIL adc_valid_width got=%b exp=0", valid8); end
  endtask

  task automatic test_cmp;
    int lat;
    go8(4'h6, 8'h40, 8'h40, 8'h00);
    wait8(lat);
    $display("CMP 40,40 -> res=%h flag=%h lat=%0d", res8, flag8, lat);
    total++; if (res8 !== 8'h40)  begin bad++; $display("FAIL cmp_eq_res got=%h exp=40", res8); end
    total++; if (flag8 !== 8'h03) begin bad++; $display("FAIL cmp_eq_flag got=%h exp=03", flag8); end
    go8(4'h6, 8'h10, 8'h20, 8'h00);
    wait8(lat);
    $display("CMP 10,20 -> res=%h flag=%h lat=%0d", res8, flag8, lat);
    total++; if (res8 !== 8'h10)  begin bad++; $display("FAIL cmp_lt_res got=%h exp=10", res8); end
    total++; if (flag8 !== 8'h80) begin bad++; $display("FAIL cmp_lt_flag got=%h exp=80", flag8); end
  endtask

  // {op, A, B, P, expected res, expected flags}
  localparam logic [43:0] TV [13] = '{
    {4'h0, 8'h0F, 8'hF0, 8'h01, 8'hFF, 8'h81},
    {4'h1, 8'h0F, 8'hF0, 8'h40, 8'h00, 8'h42},
    {4'h2, 8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h80},
    {4'h4, 8'h12, 8'h00, 8'hC3, 8'h12, 8'hC3},
    {4'h7, 8'h50, 8'h10, 8'h01, 8'h40, 8'h01},
    {4'h7, 8'h50, 8'h10, 8'h00, 8'h3F, 8'h01},
    {4'h7, 8'h10, 8'h20, 8'h01, 8'hF0, 8'h80},
    {4'h3, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01},
    {4'hF, 8'h0F, 8'hC0, 8'h00, 8'h0F, 8'hC2},
    {4'hD, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h02},
    {4'hE, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80},
    {4'hA, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03},
    {4'hB, 8'h80, 8'h00, 8'h01, 8'h01, 8'h01}
  };

  task automatic test_ops;
    int lat;
    logic [43:0] v;
    for (int i = 0; i < 13; i++) begin
      v = TV[i];
      go8(v[43:40], v[39:32], v[31:24], v[23:16]);
      wait8(lat);
      $display("op=%h A=%h B=%h P=%h -> res=%h flag=%h lat=%0d",
               v[43:40], v[39:32], v[31:24], v[23:16], res8, flag8, lat);
      total++; if (lat != 2) begin bad++; $display("FAIL ops%0d_lat got=%0d exp=2", i, lat); end
      total++; if (res8 !== v[15:8]) begin bad++; $display("FAIL ops%0d_res got=%h exp=%h", i, res8, v[15:8]); end
      total++; if (flag8 !== v[7:0]) begin bad++; $display("FAIL ops%0d_flag got=%h exp=%h", i, flag8, v[7:0]); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    go8(4'hC, 8'h01, 8'h00, 8'h01);
    wait8(lat);
    $display("ROR 01 C=1 -> res=%h flag=%h lat=%0d", res8, flag8, lat);
    total++; if (res8 !== 8'h80)  begin bad++; $display("FAIL ror_res got=%h exp=80", res8); end
    total++; if (flag8 !== 8'h81) begin bad++; $display("FAIL ror_flag got=%h exp=81", flag8); end
    // Start the next op inside the valid cycle.
    go8(4'h9, 8'h80, 8'h00, 8'h00);
    total++; if (busy8 !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", busy8); end
    wait8(lat);
    $display("ASL 80 (back-to-back) -> res=%h flag=%h lat=%0d", res8, flag8, lat);
    total++; if (lat != 2)        begin bad++; $display("FAIL b2b_lat got=%0d exp=2", lat); end
    total++; if (res8 !== 8'h00)  begin bad++; $display("FAIL asl_res got=%h exp=00", res8); end
    total++; if (flag8 !== 8'h03) begin bad++; $display("FAIL asl_flag got=%h exp=03", flag8); end
  endtask

  task automatic test_decimal;
    int lat;
    go8(4'h3, 8'h58, 8'h46, 8'h09);
    wait8(lat);
    $display("ADC 58+46 P=09 -> res=%h flag=%h lat=%0d", res8, flag8, lat);
`ifdef ALU_DECIMAL_EN
    total++; if (lat != 3)        begin bad++; $display("FAIL dadc_lat got=%0d exp=3", lat); end
    total++; if (res8 !== 8'h05)  begin bad++; $display("FAIL dadc_res got=%h exp=05", res8); end
    total++; if (flag8 !== 8'h49) begin bad++; $display("FAIL dadc_flag got=%h exp=49", flag8); end
`else
    total++; if (lat != 2)        begin bad++; $display("FAIL dadc_lat got=%0d exp=2", lat); end
    total++; if (res8 !== 8'h9F)  begin bad++; $display("FAIL dadc_res got=%h exp=9F", res8); end
    total++; if (flag8 !== 8'hC8) begin bad++; $display("FAIL dadc_flag got=%h exp=C8", flag8); end
`endif
    go8(4'h7, 8'h10, 8'h01, 8'h09);
    wait8(lat);
    $display("SBC 10-01 P=09 -> res=%h flag=%h lat=%0d", res8, flag8, lat);
`ifdef ALU_DECIMAL_EN
    total++; if (res8 !== 8'h09)  begin bad++; $display("FAIL dsbc_res got=%h exp=09", res8); end
`else
    total++; if (res8 !== 8'h0F)  begin bad++; $display("FAIL dsbc_res got=%h exp=0F", res8); end
`endif
    total++; if (flag8 !== 8'h09) begin bad++; $display("FAIL dsbc_flag got=%h exp=09", flag8); end
  endtask

  task automatic test_mid_reset;
    int lat;
    bit seen;
    go8(4'h5, 8'h00, 8'h55, 8'h24);
    wait8(lat);
    $display("LDA 55 P=24 -> res=%h flag=%h lat=%0d", res8, flag8, lat);
    total++; if (res8 !== 8'h55)  begin bad++; $display("FAIL load_res got=%h exp=55", res8); end
    total++; if (flag8 !== 8'h24) begin bad++; $display("FAIL load_flag got=%h exp=24", flag8); end
    go8(4'h3, 8'h7F, 8'h01, 8'h00);
    rst = 1'b1;
    #1;
    total++; if (busy8 !== 1'b0)  begin bad++; $display("FAIL mrst_busy got=%b exp=0", busy8); end
    total++; if (res8 !== 8'h00)  begin bad++; $display("FAIL mrst_res got=%h exp=00", res8); end
    total++; if (flag8 !== 8'h00) begin bad++; $display("FAIL mrst_flag got=%h exp=00", flag8); end
    seen = valid8;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (valid8) seen = 1;
    end
    $display("reset mid-EXEC: busy=%b res=%h flag=%h valid_seen=%b", busy8, res8, flag8, seen);
    total++; if (seen !== 1'b0)  begin bad++; $display("FAIL mrst_no_valid got=%b exp=0", seen); end
    total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL mrst_idle got=%b exp=0", busy8); end
  endtask

  task automatic test_w16;
    bit seen;
    op16 = 4'h8; a16 = 16'hFFFF; b16 = 16'h0002; p16 = 8'hC2; start16 = 1'b1;
    @(posedge clk); #1;
    total++; if (busy16 !== 1'b1) begin bad++; $display("FAIL w16_busy got=%b exp=1", busy16); end
    // This request arrives while busy and must be dropped.
    op16 = 4'h5; b16 = 16'h1234;
    @(posedge clk); #1;
    start16 = 1'b0;
    $display("W16 ADD FFFF+0002 P=C2 -> res=%h flag=%h valid=%b", res16, flag16, valid16);
    total++; if (valid16 !== 1'b1)    begin bad++; $display("FAIL w16_valid got=%b exp=1", valid16); end
    total++; if (res16 !== 16'h0001)  begin bad++; $display("FAIL w16_res got=%h exp=0001", res16); end
    total++; if (flag16 !== 8'hC3)    begin bad++; $display("FAIL w16_flag got=%h exp=C3", flag16); end
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (valid16) seen = 1;
    end
    $display("W16 start-while-busy: valid_seen=%b res=%h busy=%b", seen, res16, busy16);
    total++; if (seen !== 1'b0)       begin bad++; $display("FAIL w16_ignored got=%b exp=0", seen); end
    total++; if (res16 !== 16'h0001)  begin bad++; $display("FAIL w16_hold got=%h exp=0001", res16); end
    total++; if (busy16 !== 1'b0)     begin bad++; $display("FAIL w16_idle got=%b exp=0", busy16); end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; p8 = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; p16 = '0;
    @(posedge clk); #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_adc;
    test_cmp;
    test_ops;
    test_back_to_back;
    test_decimal;
    test_mid_reset;
    test_w16;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
